det_sequencer: RTL and testbench



---
 rtl/det_sequencer_pkg.sv | 25 ++
 rtl/det_sequencer.sv | 130 +++++++++++++
 tb/tb_det_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/det_sequencer_pkg.sv
// ============================================================================
// det_sequencer_pkg : shared sizes and FSM encoding for det_sequencer
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package det_sequencer_pkg;

  localparam int WIDTH       = 16;
  localparam int N_ELEM      = 9;
  localparam int HOLD_CYCLES = 3;

  localparam int CNT_W  = $clog2(N_ELEM);
  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/det_sequencer.sv
// ============================================================================
// det_sequencer : serial-to-parallel matrix feeder and result collector
//                 for the determinant stage
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module det_sequencer
  import det_sequencer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic             ewr,
  input  logic [WIDTH-1:0] det_in,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready
);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    elem_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [WIDTH-1:0]    elem [N_ELEM];
  logic                accept;
  logic                last_elem;
  logic                hold_done;

  assign accept    = in_valid && (state == FILL);
  assign last_elem = (elem_cnt == CNT_W'(N_ELEM - 1));
  assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // in_ready and ewr decode the state register only, so no input reaches them
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    ewr        = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (accept && last_elem) begin
          state_next = RUN;
        end
      end
      RUN: begin
        ewr = 1'b1;
        if (hold_done) begin
          state_next = CAP;
        end
      end
      CAP: begin
        state_next = OUT;
      end
      OUT: begin
        if (res_ready) begin
          state_next = FILL;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      elem_cnt  <= '0;
      hold_cnt  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) begin
        elem[i] <= '0;
      end
    end else begin
      if (accept) begin
        elem[elem_cnt] <= in_data;
        if (last_elem) begin
          elem_cnt <= '0;
          hold_cnt <= '0;
        end else begin
          elem_cnt <= elem_cnt + CNT_W'(1);
        end
      end
      if (state == RUN) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      // The determinant keeps its sum once ewr drops, so det_in is settled here
      if (state == CAP) begin
        res_data  <= det_in;
        res_valid <= 1'b1;
      end
      if ((state == OUT) && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign out1 = elem[0];
  assign out2 = elem[1];
  assign out3 = elem[2];
  assign out4 = elem[3];
  assign out5 = elem[4];
  assign out6 = elem[5];
  assign out7 = elem[6];
  assign out8 = elem[7];
  assign out9 = elem[8];

endmodule

`default_nettype wire

// File: tb/tb_det_sequencer.sv
// ============================================================================
// tb_det_sequencer : randomized scoreboard bench for det_sequencer, with a
//                    behavioural determinant stage closing the loop
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_det_sequencer;

  typedef logic [15:0] mat_t [9];

  logic        clock;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out1, out2, out3, out4, out5, out6, out7, out8, out9;
  logic        ewr;
  logic [15:0] det_in;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          rr_mode = 0;
  logic [15:0] q_exp [$];

  det_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out8      (out8),
    .out9      (out9),
    .ewr       (ewr),
    .det_in    (det_in),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Stand-in determinant stage: load, products, sum, each gated by ewr
  logic [15:0] arr [9];
  logic [15:0] p_pos, p_neg, det_res;
  always @(posedge clock) begin
    if (ewr) begin
      arr     <= '{out1, out2, out3, out4, out5, out6, out7, out8, out9};
      p_pos   <= arr[0]*arr[4]*arr[8] + arr[1]*arr[5]*arr[6] + arr[2]*arr[3]*arr[7];
      p_neg   <= arr[2]*arr[4]*arr[6] + arr[0]*arr[5]*arr[7] + arr[1]*arr[3]*arr[8];
      det_res <= p_pos - p_neg;
    end
  end
  assign det_in = det_res;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: cofactor expansion along the first row, reduced mod 2^16
  function automatic logic [15:0] ref_det(input mat_t m);
    longint a [9];
    longint d;
    for (int i = 0; i < 9; i++) a[i] = longint'(m[i]);
    d = a[0] * (a[4] * a[8] - a[5] * a[7])
      - a[1] * (a[3] * a[8] - a[5] * a[6])
      + a[2] * (a[3] * a[7] - a[4] * a[6]);
    return d[15:0];
  endfunction

  // Consumer: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every result handshake
  initial begin
    int          run;
    bit          rv_prev;
    logic [15:0] e;
    run = 0;
    rv_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        run = 0;
        rv_prev = 1'b0;
      end else begin
        if (ewr) begin
          run++;
        end else if (run != 0) begin
          chk("ewr_len", run, 3);
          run = 0;
        end
        if (ewr || res_valid) chk("in_ready_busy", {31'd0, in_ready}, 0);
        if (res_valid && !rv_prev) chk("latency", cyc - accept_cyc, 4);
        if (res_valid) begin
          if (q_exp.size() == 0) begin
            chk("unexpected_res_valid", {31'd0, res_valid}, 0);
          end else if (res_ready) begin
            e = q_exp.pop_front();
            chk("res_data", {16'd0, res_data}, {16'd0, e});
          end
        end
        rv_prev = res_valid;
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_ewr", {31'd0, ewr}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_res_data", {16'd0, res_data}, 0);
    chk("rst_outs", {31'd0, |{out1, out2, out3, out4, out5, out6, out7, out8, out9}}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q_exp.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_state();
  endtask

  // gap: 0 back-to-back, 1 idle every other cycle, 2 random idles
  task automatic send_matrix(input mat_t m, input int gap, input int n,
                             input bit use_exp, input logic [15:0] exp_v);
    bit   ir;
    int   t;
    mat_t ov;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = m[i];
      ir = 1'b0;
      t  = 0;
      while (!ir && t < 60) begin
        @(negedge clock);
        ir = in_ready;
        @(posedge clock);
        #1;
        t++;
      end
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      if (!ir) begin
        chk("send_timeout", 0, 1);
        return;
      end
      if (i == 8) begin
        accept_cyc = cyc;
        q_exp.push_back(use_exp ? exp_v : ref_det(m));
        ov = '{out1, out2, out3, out4, out5, out6, out7, out8, out9};
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("out%0d", k + 1), {16'd0, ov[k]}, {16'd0, m[k]});
        end
      end
      if (i < n - 1) begin
        if (gap == 1) begin
          @(posedge clock);
          #1;
        end else if (gap == 2) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
        end
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q_exp.size() != 0 && t < 200) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("drain_left", q_exp.size(), 0);
  endtask

  initial begin
    mat_t m;
    int   t;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_state();

    rr_mode = 0;
    m = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    send_matrix(m, 0, 9, 1'b1, 16'd1);
    m = '{16'd2, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd4};
    send_matrix(m, 1, 9, 1'b1, 16'd24);
    m = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    send_matrix(m, 0, 9, 1'b1, 16'd0);
    m = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
    send_matrix(m, 0, 9, 1'b1, 16'hFFFF);
    drain();

    // Stall in OUT: result must hold and stray in_valid pulses be ignored
    rr_mode = 2;
    @(posedge clock);
    #1;
    m = '{16'd3, 16'd1, 16'd0, 16'd2, 16'd5, 16'd1, 16'd0, 16'd4, 16'd2};
    send_matrix(m, 0, 9, 1'b0, 16'd0);
    t = 0;
    while (!res_valid && t < 10) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("stall_wait_valid", {31'd0, res_valid}, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_data  = 16'($urandom);
      @(posedge clock);
      #1;
      chk("stall_res_valid", {31'd0, res_valid}, 1);
      chk("stall_res_data", {16'd0, res_data}, {16'd0, ref_det(m)});
      chk("stall_in_ready", {31'd0, in_ready}, 0);
    end
    in_valid = 1'b0;
    rr_mode = 0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    chk("release_res_valid", {31'd0, res_valid}, 0);
    chk("release_in_ready", {31'd0, in_ready}, 1);
    m = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    send_matrix(m, 0, 9, 1'b1, 16'd1);
    drain();

    // Reset after five accepted elements, then a fresh identity
    m = '{16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7};
    send_matrix(m, 0, 5, 1'b0, 16'd0);
    do_reset();
    m = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    send_matrix(m, 0, 9, 1'b1, 16'd1);
    drain();

    // Reset during the second RUN cycle: that matrix never produces a result
    m = '{16'd5, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd1, 16'd4};
    send_matrix(m, 0, 9, 1'b0, 16'd0);
    @(posedge clock);
    #1;
    chk("run2_ewr", {31'd0, ewr}, 1);
    do_reset();
    repeat (6) begin
      @(posedge clock);
      #1;
      chk("aborted_res_valid", {31'd0, res_valid}, 0);
    end

    // Randomized matrices with random gaps and random back-pressure
    rr_mode = 1;
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 9; k++) begin
        m[k] = (n % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      end
      send_matrix(m, 2, 9, 1'b0, 16'd0);
    end
    drain();
    rr_mode = 0;
    repeat (3) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
